// File: rtl/tick_scheduler.sv
// tick_scheduler: gates raw 1 s / 50 ms / 1 ms ticks through a RUN/PAUSE/STEP
// control FSM and a slow-motion prescaler, then serialises surviving ticks into
// one valid/ready event stream (priority speed > 1 s > scan), counting drops.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   tick_1sec/speed/scan  raw 1-cycle tick pulses
//   pause_btn, step_btn   debounced levels; rising edges act
//   slow_sel              prescale divide 2^slow_sel for speed and 1 s ticks
//   eng_ready             engine accepts the presented event this cycle
//   evt_valid, evt_id     event stream (0 scan, 1 speed, 2 1 s)
//   paused                high in PAUSE or STEP
//   overrun, drop_cnt     drop pulse and saturating drop count
module tick_scheduler #(
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1sec,
  input  logic              tick_speed,
  input  logic              tick_scan,
  input  logic              pause_btn,
  input  logic              step_btn,
  input  logic [1:0]        slow_sel,
  input  logic              eng_ready,
  output logic              evt_valid,
  output logic [1:0]        evt_id,
  output logic              paused,
  output logic              overrun,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned SUM_W = DROP_W + 2;
  localparam logic [SUM_W-1:0] DROP_MAX = {2'b00, {DROP_W{1'b1}}};

  localparam logic [1:0] ID_SCAN  = 2'd0;
  localparam logic [1:0] ID_SPEED = 2'd1;
  localparam logic [1:0] ID_SEC   = 2'd2;

  typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_STEP} state_e;

  state_e             state_q, state_d;
  logic               pause_prev_q, step_prev_q;
  logic [CNT_W-1:0]   spd_cnt_q, spd_cnt_d;
  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [2:0]         pend_q, pend_d;
  logic               evt_valid_q, evt_valid_d;
  logic [1:0]         evt_id_q, evt_id_d;
  logic               paused_q, paused_d;
  logic               overrun_q, overrun_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               pause_edge, step_edge;
  logic [CNT_W-1:0]   mask;
  logic [2:0]         gated, clr, keep, drop;
  logic [SUM_W-1:0]   drop_sum;

  // Button rising edges; prev regs reset high so a held button gives no edge
  always_comb begin
    pause_edge = pause_btn & ~pause_prev_q;
    step_edge  = step_btn & ~step_prev_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Next-state logic; in STEP a pause edge wins over a coincident speed tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (pause_edge) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (pause_edge)     state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (pause_edge)      state_d = ST_RUN;
        else if (tick_speed) state_d = ST_PAUSE;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: tick gating, prescaler advance and the paused flag
  always_comb begin
    gated     = 3'b000;
    spd_cnt_d = spd_cnt_q;
    sec_cnt_d = sec_cnt_q;
    paused_d  = (state_d != ST_RUN);
    unique case (slow_sel)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    gated[ID_SCAN] = tick_scan;
    if (state_q == ST_RUN) begin
      if (tick_speed) begin
        gated[ID_SPEED] = ((spd_cnt_q & mask) == 3'd0);
        spd_cnt_d       = spd_cnt_q + 3'd1;
      end
      if (tick_1sec) begin
        gated[ID_SEC] = ((sec_cnt_q & mask) == 3'd0);
        sec_cnt_d     = sec_cnt_q + 3'd1;
      end
    end else if (state_q == ST_STEP) begin
      // single step bypasses the prescaler
      gated[ID_SPEED] = tick_speed & ~pause_edge;
    end
  end

  // Output load, pending flags and drop accounting
  always_comb begin
    clr         = 3'b000;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    if (!evt_valid_q || eng_ready) begin
      if (pend_q[ID_SPEED]) begin
        evt_valid_d = 1'b1; evt_id_d = ID_SPEED; clr[ID_SPEED] = 1'b1;
      end else if (pend_q[ID_SEC]) begin
        evt_valid_d = 1'b1; evt_id_d = ID_SEC;   clr[ID_SEC]   = 1'b1;
      end else if (pend_q[ID_SCAN]) begin
        evt_valid_d = 1'b1; evt_id_d = ID_SCAN;  clr[ID_SCAN]  = 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    keep      = pend_q & ~clr;
    drop      = gated & keep;
    pend_d    = keep | gated;
    overrun_d = |drop;
    drop_sum  = {2'b00, drop_cnt_q} + SUM_W'(drop[0]) + SUM_W'(drop[1])
              + SUM_W'(drop[2]);
    drop_cnt_d = (drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0]
                                       : drop_sum[DROP_W-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_prev_q <= 1'b1;
      step_prev_q  <= 1'b1;
      spd_cnt_q    <= '0;
      sec_cnt_q    <= '0;
      pend_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      paused_q     <= 1'b0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      pause_prev_q <= pause_btn;
      step_prev_q  <= step_btn;
      spd_cnt_q    <= spd_cnt_d;
      sec_cnt_q    <= sec_cnt_d;
      pend_q       <= pend_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      paused_q     <= paused_d;
      overrun_q    <= overrun_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign paused    = paused_q;
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
